// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory stage: EX/WB payloads, data-bus request/response and the beat FSM.
// Bus structs are sized for the widest supported bus; narrower configurations use the low lanes.
package mem_access_unit_pkg;

    localparam int DBUS_MAX_BYTES = 16;

    localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;

    typedef enum logic [3:0] {
        OP_ALU, OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD
    } op_t;

    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

    typedef enum logic [1:0] {BEAT0, BEAT1, DONE} mem_fsm_t;

    typedef struct packed {
        op_t  op;
        logic mem_read;
        logic mem_write;
        logic regwrite;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [31:0] instr;
        logic [63:0] aluout;
        logic [63:0] rd;
        logic [11:0] csr_addr;
        logic [63:0] csr_data;
    } exec_data_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [31:0] instr;
        logic [63:0] writedata;
        logic [63:0] mem_addr;
        logic [11:0] csr_addr;
        logic [63:0] csr_data;
    } mem_data_t;

    typedef struct packed {
        logic                          valid;
        logic [63:0]                   addr;
        msize_t                        size;
        logic [DBUS_MAX_BYTES-1:0]     strobe;
        logic [8*DBUS_MAX_BYTES-1:0]   data;
    } dbus_req_t;

    typedef struct packed {
        logic                          addr_ok;
        logic                          data_ok;
        logic [8*DBUS_MAX_BYTES-1:0]   data;
    } dbus_resp_t;

    function automatic logic [3:0] op_nbytes(input op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_nbytes = 4'd1;
            OP_LH, OP_LHU, OP_SH: op_nbytes = 4'd2;
            OP_LW, OP_LWU, OP_SW: op_nbytes = 4'd4;
            default:              op_nbytes = 4'd8;
        endcase
    endfunction

    function automatic msize_t op_msize(input op_t op);
        case (op_nbytes(op))
            4'd1:    op_msize = MSIZE1;
            4'd2:    op_msize = MSIZE2;
            4'd4:    op_msize = MSIZE4;
            default: op_msize = MSIZE8;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Combinational lane steering: store strobe/data placed into a two-bus-word window,
// and sign/zero extension of the captured load bytes.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int BUS_BYTES = 8
) (
    input  op_t                            i_op,
    input  logic [$clog2(BUS_BYTES)-1:0]   i_off,
    input  logic [63:0]                    i_wdata,
    input  logic [63:0]                    i_lbuf,
    output logic [2*BUS_BYTES-1:0]         o_strobe_win,
    output logic [16*BUS_BYTES-1:0]        o_data_win,
    output logic [63:0]                    o_load_ext
);

    localparam int WIN_BYTES = 2 * BUS_BYTES;

    logic [7:0] w_mask;

    // Byte-enable pattern for the access width, before positioning
    always_comb begin
        w_mask = 8'h00;
        case (op_nbytes(i_op))
            4'd1:    w_mask = 8'h01;
            4'd2:    w_mask = 8'h03;
            4'd4:    w_mask = 8'h0F;
            default: w_mask = 8'hFF;
        endcase
    end

    assign o_strobe_win = WIN_BYTES'(w_mask) << i_off;
    assign o_data_win   = (8*WIN_BYTES)'(i_wdata) << {i_off, 3'b000};

    // Load result extension from the low bytes of the capture buffer
    always_comb begin
        o_load_ext = i_lbuf;
        case (i_op)
            OP_LB:   o_load_ext = {{56{i_lbuf[7]}},  i_lbuf[7:0]};
            OP_LH:   o_load_ext = {{48{i_lbuf[15]}}, i_lbuf[15:0]};
            OP_LW:   o_load_ext = {{32{i_lbuf[31]}}, i_lbuf[31:0]};
            OP_LBU:  o_load_ext = {56'd0, i_lbuf[7:0]};
            OP_LHU:  o_load_ext = {48'd0, i_lbuf[15:0]};
            OP_LWU:  o_load_ext = {32'd0, i_lbuf[31:0]};
            default: o_load_ext = i_lbuf;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage between EX and WB: issues one or two aligned bus beats per access,
// or traps misaligned accesses when splitting is disabled.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int BUS_BYTES      = 8,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  exec_data_t  dataE,
    input  dbus_resp_t  dresp,
    output dbus_req_t   dreq,
    output mem_data_t   dataM,
    output logic        readyM,
    input  logic        all_ready,
    output logic        exc_valid,
    output logic [3:0]  exc_code
);

    localparam int OFFW     = $clog2(BUS_BYTES);
    localparam int BUS_BITS = 8 * BUS_BYTES;

    mem_fsm_t                r_state;
    mem_fsm_t                w_state_nxt;
    logic [63:0]             r_lbuf;
    logic [OFFW-1:0]         w_off;
    logic [3:0]              w_nbytes;
    logic [OFFW:0]           w_end;
    logic [OFFW:0]           w_hi_shift;
    logic                    w_cross;
    logic                    w_natmis;
    logic                    w_mem_access;
    logic                    w_fault;
    logic                    w_beat;
    logic                    w_req_valid;
    logic                    w_take;
    logic [63:0]             w_aligned;
    logic [BUS_BITS-1:0]     w_rdata;
    logic [2*BUS_BYTES-1:0]  w_strobe_win;
    logic [16*BUS_BYTES-1:0] w_data_win;
    logic [63:0]             w_load_ext;
    logic                    w_unused;

    assign w_off        = dataE.aluout[OFFW-1:0];
    assign w_nbytes     = op_nbytes(dataE.ctl.op);
    assign w_end        = {1'b0, w_off} + (OFFW+1)'(w_nbytes);
    assign w_cross      = w_end > (OFFW+1)'(BUS_BYTES);
    assign w_natmis     = (dataE.aluout[2:0] & (w_nbytes[2:0] - 3'd1)) != 3'd0;
    assign w_mem_access = dataE.ctl.mem_read | dataE.ctl.mem_write;
    assign w_fault      = w_mem_access & (ALLOW_MISALIGN == 1'b0) & w_natmis;
    assign w_beat       = (r_state == BEAT0) | (r_state == BEAT1);
    assign w_req_valid  = w_mem_access & ~w_fault & w_beat;
    assign w_take       = w_req_valid & dresp.data_ok & ~all_ready;
    assign w_aligned    = {dataE.aluout[63:OFFW], {OFFW{1'b0}}};
    assign w_rdata      = dresp.data[BUS_BITS-1:0];
    assign w_hi_shift   = (OFFW+1)'(BUS_BYTES) - {1'b0, w_off};
    assign w_unused     = ^{dresp.addr_ok, dresp.data};

    mem_lane_align #(.BUS_BYTES(BUS_BYTES)) u_lane (
        .i_op         (dataE.ctl.op),
        .i_off        (w_off),
        .i_wdata      (dataE.rd),
        .i_lbuf       (r_lbuf),
        .o_strobe_win (w_strobe_win),
        .o_data_win   (w_data_win),
        .o_load_ext   (w_load_ext)
    );

    // Beat sequencing; a pipeline advance restarts at BEAT0 even if a beat completes
    always_comb begin
        w_state_nxt = r_state;
        if (all_ready) begin
            w_state_nxt = BEAT0;
        end else begin
            case (r_state)
                BEAT0: begin
                    if (w_req_valid && dresp.data_ok) w_state_nxt = w_cross ? BEAT1 : DONE;
                    else                              w_state_nxt = BEAT0;
                end
                BEAT1: begin
                    if (w_req_valid && dresp.data_ok) w_state_nxt = DONE;
                    else                              w_state_nxt = BEAT1;
                end
                DONE: begin
                    if (!w_mem_access) w_state_nxt = BEAT0;
                    else               w_state_nxt = DONE;
                end
                default: w_state_nxt = BEAT0;
            endcase
        end
    end

    // State register and load capture; the second beat supplies the bytes above the first word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BEAT0;
            r_lbuf  <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                if (r_state == BEAT0) r_lbuf <= 64'(w_rdata >> {w_off, 3'b000});
                else                  r_lbuf <= r_lbuf | 64'(w_rdata << {w_hi_shift, 3'b000});
            end
        end
    end

    // Bus request: natural single beat, or the lower/upper half of the split window
    always_comb begin
        dreq       = '0;
        dreq.valid = w_req_valid;
        if (!w_cross) begin
            dreq.addr   = dataE.aluout;
            dreq.size   = op_msize(dataE.ctl.op);
            dreq.strobe = DBUS_MAX_BYTES'(w_strobe_win[BUS_BYTES-1:0]);
            dreq.data   = (8*DBUS_MAX_BYTES)'(w_data_win[BUS_BITS-1:0]);
        end else if (r_state == BEAT1) begin
            dreq.addr   = w_aligned + 64'(BUS_BYTES);
            dreq.size   = MSIZE8;
            dreq.strobe = DBUS_MAX_BYTES'(w_strobe_win[2*BUS_BYTES-1:BUS_BYTES]);
            dreq.data   = (8*DBUS_MAX_BYTES)'(w_data_win[2*BUS_BITS-1:BUS_BITS]);
        end else begin
            dreq.addr   = w_aligned;
            dreq.size   = MSIZE8;
            dreq.strobe = DBUS_MAX_BYTES'(w_strobe_win[BUS_BYTES-1:0]);
            dreq.data   = (8*DBUS_MAX_BYTES)'(w_data_win[BUS_BITS-1:0]);
        end
    end

    // Stage result and exception reporting
    always_comb begin
        dataM.ctl      = dataE.ctl;
        dataM.dst      = dataE.dst;
        dataM.instr    = dataE.instr;
        dataM.mem_addr = dataE.aluout;
        dataM.csr_addr = dataE.csr_addr;
        dataM.csr_data = dataE.csr_data;
        if (dataE.ctl.mem_read && !w_fault) dataM.writedata = w_load_ext;
        else                                dataM.writedata = dataE.aluout;
        readyM    = ~w_mem_access | w_fault | (r_state == DONE);
        exc_valid = w_fault;
        if (!w_fault)                exc_code = 4'd0;
        else if (dataE.ctl.mem_read) exc_code = EXC_LOAD_MISALIGNED;
        else                         exc_code = EXC_STORE_MISALIGNED;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: expected bus beats and stage results are queued at stimulus time and
// popped by monitors on each bus handshake and each pipeline advance.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    typedef struct {
        logic [63:0]  addr;
        msize_t       size;
        logic [15:0]  strobe;
        logic [127:0] data;
    } beat_t;

    typedef struct {
        logic [63:0] wdata;
        logic [63:0] maddr;
        logic        ev;
        logic [3:0]  code;
        logic [4:0]  dst;
    } res_t;

    logic       clk = 1'b0;
    logic       reset;
    exec_data_t dataE, dataE2;
    dbus_resp_t dresp, dresp2;
    dbus_req_t  dreq, dreq2;
    mem_data_t  dataM, dataM2;
    logic       readyM, readyM2, all_ready, all_ready2, exc_valid, exc_valid2;
    logic [3:0] exc_code, exc_code2;

    int checks = 0;
    int errors = 0;
    beat_t beatq[$];
    res_t  resq[$];
    res_t  trapq[$];

    always #5 clk = ~clk;

    mem_access_unit #(.BUS_BYTES(8), .ALLOW_MISALIGN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .dataE(dataE), .dresp(dresp), .dreq(dreq), .dataM(dataM),
        .readyM(readyM), .all_ready(all_ready), .exc_valid(exc_valid), .exc_code(exc_code)
    );

    mem_access_unit #(.BUS_BYTES(8), .ALLOW_MISALIGN(1'b0)) u_trap (
        .clk(clk), .reset(reset), .dataE(dataE2), .dresp(dresp2), .dreq(dreq2), .dataM(dataM2),
        .readyM(readyM2), .all_ready(all_ready2), .exc_valid(exc_valid2), .exc_code(exc_code2)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exec_data_t mk(input op_t op, input logic [63:0] addr, input logic [63:0] rd);
        exec_data_t d;
        d = '0;
        d.ctl.op        = op;
        d.ctl.mem_read  = op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
        d.ctl.mem_write = op inside {OP_SB, OP_SH, OP_SW, OP_SD};
        d.ctl.regwrite  = !d.ctl.mem_write;
        d.dst           = 5'd9;
        d.instr         = 32'h0000_0013;
        d.aluout        = addr;
        d.rd            = rd;
        return d;
    endfunction

    task automatic exp_beat(input logic [63:0] a, input msize_t s, input logic [15:0] st, input logic [127:0] d);
        beat_t e;
        e.addr = a; e.size = s; e.strobe = st; e.data = d;
        beatq.push_back(e);
    endtask

    task automatic exp_res(input logic [63:0] w, input logic [63:0] ma);
        res_t r;
        r.wdata = w; r.maddr = ma; r.ev = 1'b0; r.code = 4'd0; r.dst = 5'd9;
        resq.push_back(r);
    endtask

    // Bus-beat monitor and result monitors for both instances
    always @(negedge clk) begin
        if (!reset && dreq.valid && dresp.data_ok) begin
            if (beatq.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat_unexpected: got request addr 0x%0h expected none", dreq.addr);
            end else begin
                beat_t e;
                e = beatq.pop_front();
                chk("beat_addr",   128'(dreq.addr),   128'(e.addr));
                chk("beat_size",   128'(dreq.size),   128'(e.size));
                chk("beat_strobe", 128'(dreq.strobe), 128'(e.strobe));
                chk("beat_data",   128'(dreq.data),   e.data);
            end
        end
        if (!reset && all_ready && readyM) begin
            if (resq.size() == 0) begin
                checks++; errors++;
                $display("FAIL res_unexpected: got writedata 0x%0h expected none", dataM.writedata);
            end else begin
                res_t r;
                r = resq.pop_front();
                chk("res_writedata", 128'(dataM.writedata), 128'(r.wdata));
                chk("res_mem_addr",  128'(dataM.mem_addr),  128'(r.maddr));
                chk("res_dst",       128'(dataM.dst),       128'(r.dst));
                chk("res_exc_valid", 128'(exc_valid),       128'(r.ev));
                chk("res_exc_code",  128'(exc_code),        128'(r.code));
            end
        end
        if (!reset && all_ready2 && readyM2) begin
            if (trapq.size() == 0) begin
                checks++; errors++;
                $display("FAIL trap_unexpected: got exc_code 0x%0h expected none", exc_code2);
            end else begin
                res_t r;
                r = trapq.pop_front();
                chk("trap_writedata", 128'(dataM2.writedata), 128'(r.wdata));
                chk("trap_exc_valid", 128'(exc_valid2),       128'(r.ev));
                chk("trap_exc_code",  128'(exc_code2),        128'(r.code));
            end
        end
    end

    // One access on u_dut: beats answered after lat idle cycles, then one advance cycle
    task automatic run_access(input op_t op, input logic [63:0] addr, input logic [63:0] rd,
                              input int nbeats, input logic [63:0] d0, input logic [63:0] d1,
                              input int lat, input bit stray_ok);
        dataE = mk(op, addr, rd);
        #1;
        chk("req_valid_start", 128'(dreq.valid), 128'(1));
        for (int b = 0; b < nbeats; b++) begin
            for (int w = 0; w < lat; w++) begin
                chk("ready_while_wait", 128'(readyM), 128'(0));
                @(posedge clk); #1;
            end
            dresp.data_ok = 1'b1;
            dresp.data    = 128'((b == 0) ? d0 : d1);
            @(posedge clk); #1;
            dresp.data_ok = 1'b0;
            dresp.data    = 128'h5A5A_5A5A_5A5A_5A5A_A5A5_A5A5_A5A5_A5A5;
            if (b < nbeats - 1) chk("ready_mid_split", 128'(readyM), 128'(0));
        end
        chk("ready_after_ok", 128'(readyM), 128'(1));
        chk("valid_after_ok", 128'(dreq.valid), 128'(0));
        if (stray_ok) begin
            dresp.data_ok = 1'b1;
            dresp.data    = 128'hDEAD_DEAD_DEAD_DEAD;
            @(posedge clk); #1;
            dresp.data_ok = 1'b0;
            chk("ready_after_stray", 128'(readyM), 128'(1));
        end
        all_ready = 1'b1;
        @(posedge clk); #1;
        all_ready = 1'b0;
        dataE = mk(OP_ALU, 64'd0, 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        all_ready  = 1'b0;
        all_ready2 = 1'b0;
        dataE      = mk(OP_ALU, 64'd0, 64'd0);
        dataE2     = mk(OP_ALU, 64'd0, 64'd0);
        dresp      = '0;
        dresp2     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_readyM",    128'(readyM),     128'(1));
        chk("reset_valid",     128'(dreq.valid), 128'(0));
        chk("reset_exc_valid", 128'(exc_valid),  128'(0));
        chk("reset_exc_code",  128'(exc_code),   128'(0));
        @(posedge clk); #1;

        // Aligned LD, two-cycle latency, stray data_ok while in DONE
        exp_beat(64'h1000, MSIZE8, 16'h00FF, 128'h0);
        exp_res(64'h1122_3344_5566_7788, 64'h1000);
        run_access(OP_LD, 64'h1000, 64'h0, 1, 64'h1122_3344_5566_7788, 64'h0, 2, 1'b1);

        // Non-memory op advances with zero latency
        dataE = mk(OP_ALU, 64'h55, 64'h77);
        exp_res(64'h55, 64'h55);
        #1;
        chk("alu_readyM", 128'(readyM), 128'(1));
        chk("alu_valid",  128'(dreq.valid), 128'(0));
        all_ready = 1'b1;
        @(posedge clk); #1;
        all_ready = 1'b0;
        dataE = mk(OP_ALU, 64'd0, 64'd0);

        // Split LD across the word boundary
        exp_beat(64'h1000, MSIZE8, 16'h00E0, 128'h0);
        exp_beat(64'h1008, MSIZE8, 16'h001F, 128'h0);
        exp_res(64'hCCBB_AA99_0088_7766, 64'h1005);
        run_access(OP_LD, 64'h1005, 64'h0, 2, 64'h8877_6655_4433_2211, 64'hFFEE_DDCC_BBAA_9900, 1, 1'b0);

        // Split SW
        exp_beat(64'h1008, MSIZE8, 16'h00C0, 128'hBEEF_0000_0000_0000);
        exp_beat(64'h1010, MSIZE8, 16'h0003, 128'h0000_0000_0000_DEAD);
        exp_res(64'h100E, 64'h100E);
        run_access(OP_SW, 64'h100E, 64'hDEAD_BEEF, 2, 64'h0, 64'h0, 0, 1'b0);

        // Sub-word loads with sign and zero extension
        exp_beat(64'h1007, MSIZE1, 16'h0080, 128'h0);
        exp_res(64'hFFFF_FFFF_FFFF_FF80, 64'h1007);
        run_access(OP_LB, 64'h1007, 64'h0, 1, 64'h8012_3456_789A_BCDE, 64'h0, 0, 1'b0);
        exp_beat(64'h1007, MSIZE1, 16'h0080, 128'h0);
        exp_res(64'h80, 64'h1007);
        run_access(OP_LBU, 64'h1007, 64'h0, 1, 64'h8012_3456_789A_BCDE, 64'h0, 1, 1'b0);
        exp_beat(64'h1002, MSIZE2, 16'h000C, 128'h0);
        exp_res(64'hFFFF_FFFF_FFFF_8001, 64'h1002);
        run_access(OP_LH, 64'h1002, 64'h0, 1, 64'h1234_5678_8001_ABCD, 64'h0, 0, 1'b0);
        exp_beat(64'h1002, MSIZE2, 16'h000C, 128'h0);
        exp_res(64'h8001, 64'h1002);
        run_access(OP_LHU, 64'h1002, 64'h0, 1, 64'h1234_5678_8001_ABCD, 64'h0, 0, 1'b0);
        exp_beat(64'h1004, MSIZE4, 16'h00F0, 128'h0);
        exp_res(64'hFFFF_FFFF_89AB_CDEF, 64'h1004);
        run_access(OP_LW, 64'h1004, 64'h0, 1, 64'h89AB_CDEF_0123_4567, 64'h0, 0, 1'b0);
        exp_beat(64'h1004, MSIZE4, 16'h00F0, 128'h0);
        exp_res(64'h89AB_CDEF, 64'h1004);
        run_access(OP_LWU, 64'h1004, 64'h0, 1, 64'h89AB_CDEF_0123_4567, 64'h0, 0, 1'b0);

        // Misaligned but within one word: single beat, no exception in split mode
        exp_beat(64'h1003, MSIZE2, 16'h0018, 128'h0);
        exp_res(64'h1234, 64'h1003);
        run_access(OP_LH, 64'h1003, 64'h0, 1, 64'h0000_0012_3400_0000, 64'h0, 0, 1'b0);

        // Narrow and full stores
        exp_beat(64'h1003, MSIZE1, 16'h0008, 128'hA500_0000);
        exp_res(64'h1003, 64'h1003);
        run_access(OP_SB, 64'h1003, 64'hA5, 1, 64'h0, 64'h0, 0, 1'b0);
        exp_beat(64'h1010, MSIZE8, 16'h00FF, 128'h0123_4567_89AB_CDEF);
        exp_res(64'h1010, 64'h1010);
        run_access(OP_SD, 64'h1010, 64'h0123_4567_89AB_CDEF, 1, 64'h0, 64'h0, 0, 1'b0);

        // Trap mode: misaligned load/store fault, aligned access still requests
        dataE2 = mk(OP_LH, 64'h1003, 64'h0);
        trapq.push_back('{64'h1003, 64'h1003, 1'b1, 4'd4, 5'd9});
        #1;
        chk("trap_ld_ready",  128'(readyM2),     128'(1));
        chk("trap_ld_no_req", 128'(dreq2.valid), 128'(0));
        all_ready2 = 1'b1;
        @(posedge clk); #1;
        all_ready2 = 1'b0;
        dataE2 = mk(OP_SH, 64'h1003, 64'hBEEF);
        trapq.push_back('{64'h1003, 64'h1003, 1'b1, 4'd6, 5'd9});
        #1;
        chk("trap_st_ready",  128'(readyM2),     128'(1));
        chk("trap_st_no_req", 128'(dreq2.valid), 128'(0));
        all_ready2 = 1'b1;
        @(posedge clk); #1;
        all_ready2 = 1'b0;
        dataE2 = mk(OP_LW, 64'h1004, 64'h0);
        #1;
        chk("trap_aligned_exc",   128'(exc_valid2),  128'(0));
        chk("trap_aligned_code",  128'(exc_code2),   128'(0));
        chk("trap_aligned_req",   128'(dreq2.valid), 128'(1));
        chk("trap_aligned_ready", 128'(readyM2),     128'(0));
        dataE2 = mk(OP_ALU, 64'd0, 64'd0);
        @(posedge clk); #1;

        // Reset after the first beat of a split load abandons the second beat
        exp_beat(64'h1000, MSIZE8, 16'h00E0, 128'h0);
        dataE = mk(OP_LD, 64'h1005, 64'h0);
        dresp.data_ok = 1'b1;
        dresp.data    = 128'h8877_6655_4433_2211;
        @(posedge clk); #1;
        dresp.data_ok = 1'b0;
        chk("split_beat1_valid", 128'(dreq.valid), 128'(1));
        chk("split_beat1_addr",  128'(dreq.addr),  128'(64'h1008));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("post_reset_valid", 128'(dreq.valid), 128'(1));
        chk("post_reset_addr",  128'(dreq.addr),  128'(64'h1000));
        chk("post_reset_ready", 128'(readyM),     128'(0));
        dataE = mk(OP_ALU, 64'd0, 64'd0);
        #1;
        chk("post_reset_idle", 128'(dreq.valid), 128'(0));

        repeat (3) @(posedge clk);
        #1;
        chk("beatq_drained", 128'(beatq.size()), 128'(0));
        chk("resq_drained",  128'(resq.size()),  128'(0));
        chk("trapq_drained", 128'(trapq.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised successor to the pipeline memory stage. Sits between EX and WB, takes `exec_data_t` from EX, drives the data bus, and delivers `mem_data_t` to WB. Adds a configurable bus width and two misalignment modes. In split mode, an access that crosses a bus-word boundary becomes two aligned bus beats. In trap mode, a misaligned access raises an exception and never reaches the bus.

## Interface
- `BUS_BYTES`, default 8: dbus data width in bytes (power of two, ≥ 8).
- `ALLOW_MISALIGN`, default 1: 1 = split crossing accesses; 0 = trap on any non-natural alignment.

Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `dataE` in `exec_data_t`: EX result (`aluout` = address, `rd` = store data, `ctl.op`, `ctl.mem_read/mem_write`).
- `dresp` in `dbus_resp_t`: bus response; a beat completes on `data_ok`.
- `dreq` out `dbus_req_t`: bus request.
- `dataM` out `mem_data_t`: to WB.
- `readyM` out 1: stage result valid.
- `all_ready` in 1: global advance; the pipeline moves this cycle.
- `exc_valid` out 1: misaligned-address exception.
- `exc_code` out 4: 4 = load misaligned, 6 = store misaligned; 0 when `exc_valid` = 0.

## Operation
- `nbytes` is 8/4/2/1 from op (D/W/H/B). `off` = `aluout[log2(BUS_BYTES)-1:0]`.
- `cross` = `off + nbytes > BUS_BYTES`.
- `natmis` = `aluout % nbytes != 0`.
- `mem_access` = `mem_read | mem_write`.
- `fault` = `mem_access & !ALLOW_MISALIGN & natmis`.
  - `exc_valid` = `fault`.
  - No bus request is issued.
  - `readyM` = 1.
  - `dataM.writedata` = `aluout`.
- FSM with states BEAT0, BEAT1, DONE. Reset state is BEAT0.
  - BEAT0 → DONE on `data_ok` when `!cross`.
  - BEAT0 → BEAT1 on `data_ok` when `cross`.
  - BEAT1 → DONE on `data_ok`.
  - DONE → BEAT0 when `!mem_access`.
  - `all_ready` forces BEAT0 from any state; it has priority over `data_ok`.
- `dreq.valid` = `mem_access & !fault & state ∈ {BEAT0, BEAT1}`.
- Single beat (`!cross`): `addr` = `aluout`, `size` from op, `strobe` = `((1<<nbytes)-1) << off`, `data` = `rd << 8*off`.
- Split: 64-bit-per-lane shift into a 2×BUS_BYTES window.
  - BEAT0: `addr` = `aluout` aligned down, `size` = MSIZE8, lower half of the window's strobe and data.
  - BEAT1: `addr` = aligned + `BUS_BYTES`, upper half.
- Load capture:
  - BEAT0 stores `dresp.data >> 8*off`.
  - BEAT1 ORs in `dresp.data << 8*(BUS_BYTES-off)`.
  - Sign or zero extension per op (LB/LH/LW/LD/LBU/LHU/LWU) is applied at the output from the `nbytes` low bytes.
- Non-load ops: `writedata` = `aluout`.
- `ctl`, `dst`, `instr`, `csr_addr`, `csr_data` pass through from `dataE`; `mem_addr` = `aluout`.
- `readyM` = `!mem_access | fault | state == DONE`.

## Timing
- Reset values: state BEAT0, load buffer 0. Reset applied mid-beat aborts the access; `dreq.valid` follows the BEAT0 rule on the next cycle.
- Single-beat access:
  - `data_ok` at cycle N → `readyM` = 1 at N+1.
  - `dreq.valid` falls at N+1.
- Split access:
  - BEAT0 `data_ok` at N → BEAT1 `valid` at N+1 with the new address.
  - BEAT1 `data_ok` at M → `readyM` at M+1.
- `valid`, `addr`, `size`, `strobe` and `data` stay stable while a beat awaits `data_ok`. `dresp.data` is sampled only on `data_ok`.
- Non-memory ops and faults have zero added latency; `readyM` is combinational.
- `data_ok` arriving in DONE is ignored.

## Structure
- `pipeline` package gains:
  - `mem_fsm_t` enum (BEAT0, BEAT1, DONE).
  - `EXC_LOAD_MISALIGNED` = 4 and `EXC_STORE_MISALIGNED` = 6.
  - An `op_nbytes` function.
- One combinational sub-module, `mem_lane_align`, builds the window strobe/data for stores and the sign/zero extension for loads. The FSM and capture register stay in `mem_access_unit`.

## Test plan
- LD at 0x1000, `data_ok` after 2 cycles with 0x1122334455667788 → one beat, `writedata` 0x1122334455667788, `readyM` 1 cycle after `data_ok`.
- LD at 0x1005 (split):
  - beat0 addr 0x1000 returns 0x8877665544332211.
  - beat1 addr 0x1008 returns 0xFFEEDDCCBBAA9900.
  - `writedata` = 0xCCBBAA9900887766.
- SW at 0x100E, `rd` = 0xDEADBEEF:
  - beat0 addr 0x1008, strobe 0xC0, data 0xBEEF000000000000.
  - beat1 addr 0x1010, strobe 0x03, data 0x000000000000DEAD.
- LH at 0x1003 with `ALLOW_MISALIGN` = 0 → `exc_valid` = 1, `exc_code` = 4, no `dreq.valid`, `readyM` = 1 same cycle. SH at 0x1003 → `exc_code` = 6.
- LB at 0x1007 returning byte 0x80 → `writedata` 0xFFFFFFFFFFFFFF80. LBU → 0x80.
- Reset asserted the cycle after BEAT0 `data_ok` of a split load → next cycle state is BEAT0 and no BEAT1 request is issued. Non-memory op with `all_ready` → `readyM` = 1 and the FSM stays in BEAT0.
